// File: rtl/axi4_arb_pkg.sv
// Shared types and helpers for the AXI4 read/write arbiters.
// rr_pick is written for up to MAX_M requesters; callers zero-extend req/ptr.
package axi4_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam int unsigned MAX_M = 8;

    // First set bit of req at or above ptr, wrapping modulo n.
    function automatic logic [2:0] rr_pick(input logic [MAX_M-1:0] req,
                                           input logic [2:0]       ptr,
                                           input int unsigned      n);
        logic [2:0] win;
        logic [2:0] idx;
        logic       found;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_M; i++) begin
            idx = 3'((32'(ptr) + i) % n);
            if (i < n && !found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axi4_rr_picker.sv
// Combinational round-robin winner select over NUM_M requesters (2..8).
// Shared by the read- and write-side arbiters.
module axi4_rr_picker
    import axi4_arb_pkg::*;
#(
    parameter  int unsigned NUM_M = 2,
    localparam int unsigned GW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [GW-1:0]    ptr_i,
    output logic [GW-1:0]    winner_o
);

    assign winner_o = GW'(rr_pick(8'(req_i), 3'(ptr_i), NUM_M));

endmodule

// File: rtl/axi4_rd_arbiter.sv
// AXI4 read-port arbiter: one slave AR/R port shared by NUM_M requesters, grant held per burst.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axi4_rd_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_M      = 2,
    parameter int unsigned GW         = $clog2(NUM_M)
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [NUM_M*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_M*8-1:0]          s_arlen,
    input  logic [NUM_M*3-1:0]          s_arsize,
    input  logic [NUM_M-1:0]            s_arvalid,
    output logic [NUM_M-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]       s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rlast,
    output logic [NUM_M-1:0]            s_rvalid,
    input  logic [NUM_M-1:0]            s_rready,
    output logic [ADDR_WIDTH-1:0]       m_araddr,
    output logic [7:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [DATA_WIDTH-1:0]       m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rlast,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic                        rlast_err
);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] winner;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic [7:0]    len_q, len_d;
    logic          rlast_err_q, rlast_err_d;

    axi4_rr_picker #(
        .NUM_M (NUM_M)
    ) u_picker (
        .req_i    (s_arvalid),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner)
    );

    // R payload is broadcast; only the owner sees rvalid.
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != IDLE);
    assign rlast_err = rlast_err_q;

    assign m_araddr = s_araddr[32'(grant_id_q) * ADDR_WIDTH +: ADDR_WIDTH];
    assign m_arlen  = s_arlen[32'(grant_id_q) * 8 +: 8];
    assign m_arsize = s_arsize[32'(grant_id_q) * 3 +: 3];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        rlast_err_d = rlast_err_q;
        s_arready   = '0;
        s_rvalid    = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|s_arvalid) begin
                    grant_id_d = winner;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                m_arvalid             = s_arvalid[grant_id_q];
                s_arready[grant_id_q] = m_arready;
                if (m_arvalid && m_arready) begin
                    len_d      = m_arlen;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                s_rvalid[grant_id_q] = m_rvalid;
                m_rready             = s_rready[grant_id_q];
                if (m_rvalid && m_rready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // The slave's RLAST still ends the burst even when it disagrees with ARLEN.
                    if (m_rlast != (beat_cnt_q == len_q)) begin
                        rlast_err_d = 1'b1;
                    end
                    if (m_rlast) begin
                        state_d = IDLE;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
                        rr_ptr_d = '0;
`else
                        rr_ptr_d = GW'((32'(grant_id_q) + 32'd1) % NUM_M);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            rlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            rlast_err_q <= rlast_err_d;
        end
    end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Scoreboard bench for axi4_rd_arbiter: random requesters and slave, queue-based service-order model.
// Builds in either arbitration mode (AXI_RD_ARB_FIXED_PRIO_EN).
module tb_axi4_rd_arbiter;
    import axi4_arb_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned N  = 2;
    localparam int unsigned GW = 1;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [N*AW-1:0] s_araddr;
    logic [N*8-1:0]  s_arlen;
    logic [N*3-1:0]  s_arsize;
    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic            m_arvalid;
    logic            m_arready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic            m_rvalid;
    logic            m_rready;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic            rlast_err;

    always #5 ACLK = ~ACLK;

    axi4_rd_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_M      (N)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .grant_id  (grant_id),
        .busy      (busy),
        .rlast_err (rlast_err)
    );

    typedef struct {
        int            m;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
    } ar_t;

    typedef struct {
        int            m;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_t;

    ar_t exp_ar[$];
    r_t  exp_r[$];
    int  checks = 0;
    int  errors = 0;

    // Requester state (held until each AR handshake), slave state and model state.
    logic          req_pend[N] = '{default: 1'b0};
    logic [AW-1:0] req_addr[N] = '{default: '0};
    logic [7:0]    req_len[N]  = '{default: '0};
    logic [2:0]    req_size[N] = '{default: '0};
    logic          sl_active   = 1'b0;
    logic [AW-1:0] sl_addr     = '0;
    logic [7:0]    sl_len      = '0;
    int            sl_beat     = 0;
    int            early_beat  = -1;
    logic          rtoggle     = 1'b0;
    int            ptr_m       = 0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input int b);
        return {a, 16'(b)};
    endfunction

    function automatic logic [1:0] rsp(input logic [AW-1:0] a, input int b);
        return (a[0] ^ b[0]) ? SLVERR : OKAY;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requesters and slave: sample handshakes at negedge, drive #1 after posedge.
    initial begin : env
        logic          ar_hs, r_hs, r_last, tog;
        logic [AW-1:0] a;
        logic [7:0]    l;
        logic [N-1:0]  s_hs;
        tog = 1'b0;
        forever begin
            @(negedge ACLK);
            ar_hs  = m_arvalid && m_arready;
            a      = m_araddr;
            l      = m_arlen;
            r_hs   = m_rvalid && m_rready;
            r_last = m_rlast;
            s_hs   = s_arvalid & s_arready;
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                sl_active = 1'b0;
                r_hs      = 1'b0;
            end else begin
                if (r_hs) begin
                    sl_beat++;
                    if (r_last) sl_active = 1'b0;
                end
                if (ar_hs) begin
                    sl_active = 1'b1;
                    sl_addr   = a;
                    sl_len    = l;
                    sl_beat   = 0;
                end
                for (int i = 0; i < N; i++) if (s_hs[i]) req_pend[i] = 1'b0;
            end
            m_arready = !sl_active && ($urandom_range(0, 3) != 0);
            m_rvalid  = sl_active && ((m_rvalid && !r_hs) || ($urandom_range(0, 3) != 0));
            m_rdata   = pat(sl_addr, sl_beat);
            m_rresp   = rsp(sl_addr, sl_beat);
            m_rlast   = sl_active && (sl_beat == int'(sl_len) || sl_beat == early_beat);
            tog       = ~tog;
            for (int i = 0; i < N; i++) begin
                s_arvalid[i]          = req_pend[i];
                s_araddr[i*AW +: AW]  = req_addr[i];
                s_arlen[i*8 +: 8]     = req_len[i];
                s_arsize[i*3 +: 3]    = req_size[i];
            end
            s_rready = rtoggle ? {N{tog}} : N'($urandom);
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        ar_t ea;
        r_t  er;
        forever begin
            @(negedge ACLK);
            if (ARESETn) begin
                if (m_arvalid && m_arready) begin
                    if (exp_ar.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ar_unexpected: got addr %0h expected no request", m_araddr);
                    end else begin
                        ea = exp_ar.pop_front();
                        check("ar_grant", 64'(grant_id), 64'(ea.m));
                        check("ar_addr", 64'(m_araddr), 64'(ea.addr));
                        check("ar_len", 64'(m_arlen), 64'(ea.len));
                        check("ar_size", 64'(m_arsize), 64'(ea.size));
                        check("ar_ready_route", 64'(s_arready), 64'(1 << ea.m));
                    end
                end
                if (m_rvalid && m_rready) begin
                    if (exp_r.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL r_unexpected: got data %0h expected no beat", s_rdata);
                    end else begin
                        er = exp_r.pop_front();
                        check("r_route", 64'(s_rvalid), 64'(1 << er.m));
                        check("r_data", 64'(s_rdata), 64'(er.data));
                        check("r_resp", 64'(s_rresp), 64'(er.resp));
                        check("r_last", 64'(s_rlast), 64'(er.last));
                    end
                end
                if (busy && !m_arvalid) check("rready_mirror", 64'(m_rready), 64'(s_rready[grant_id]));
                if (!busy) check("idle_quiet", 64'({s_rvalid, s_arready, m_arvalid, m_rready}), 64'(0));
            end
        end
    end

    // Raise requests on the masters in mask and queue the expected service order.
    task automatic issue(input logic [N-1:0] mask, input int len_sel, input logic [AW-1:0] a0);
        logic [N-1:0] set;
        int           w, nb;
        @(negedge ACLK);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_addr[i] = (a0 != '0) ? a0 + AW'(i * 16) : AW'($urandom);
                req_len[i]  = (len_sel < 0) ? 8'($urandom_range(0, 7)) : 8'(len_sel);
                req_size[i] = 3'($urandom_range(0, 5));
                req_pend[i] = 1'b1;
            end
        end
        set = mask;
        while (set != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && set[(ptr_m + k) % N]) w = (ptr_m + k) % N;
            end
            set[w] = 1'b0;
            exp_ar.push_back('{m: w, addr: req_addr[w], len: req_len[w], size: req_size[w]});
            nb = (early_beat >= 0 && early_beat < int'(req_len[w])) ? early_beat + 1
                                                                     : int'(req_len[w]) + 1;
            for (int b = 0; b < nb; b++) begin
                exp_r.push_back('{m: w, data: pat(req_addr[w], b), resp: rsp(req_addr[w], b),
                                  last: (b == nb - 1)});
            end
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
            ptr_m = 0;
`else
            ptr_m = (w + 1) % N;
`endif
        end
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while ((exp_ar.size() != 0 || exp_r.size() != 0 || busy) && cyc < 3000) begin
            @(negedge ACLK);
            cyc++;
        end
        check("burst_timeout", 64'(cyc >= 3000), 64'(0));
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cyc;
        ARESETn   = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rresp   = OKAY;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant", 64'(grant_id), 64'(0));
        check("rst_err", 64'(rlast_err), 64'(0));
        check("rst_valids", 64'({s_arready, s_rvalid, m_arvalid, m_rready}), 64'(0));
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);

        // Simultaneous requests from pointer 0, twice.
        issue(2'b11, 0, 16'h0A00);
        wait_done();
        issue(2'b11, 0, 16'h0B00);
        wait_done();

        // Single M0 request: one idle bubble, then the address.
        issue(2'b01, 3, 16'h0010);
        @(negedge ACLK);
        check("bubble_arvalid", 64'(m_arvalid), 64'(0));
        @(negedge ACLK);
        check("addr_arvalid", 64'(m_arvalid), 64'(1));
        check("addr_araddr", 64'(m_araddr), 64'(16'h0010));
        wait_done();
        issue(2'b11, 1, 16'h0C00);
        wait_done();

        // Backpressure on M1 with s_rready toggling.
        rtoggle = 1'b1;
        issue(2'b10, 7, 16'h0100);
        wait_done();
        rtoggle = 1'b0;

        for (int r = 0; r < 25; r++) begin
            issue(N'($urandom_range(1, 3)), -1, '0);
            wait_done();
        end
        check("err_clean", 64'(rlast_err), 64'(0));

        // Early RLAST on the second beat of a 4-beat burst.
        early_beat = 1;
        issue(2'b01, 3, 16'h0400);
        wait_done();
        early_beat = -1;
        check("err_set", 64'(rlast_err), 64'(1));
        issue(2'b10, -1, '0);
        wait_done();
        check("err_sticky", 64'(rlast_err), 64'(1));

        // Reset mid-burst; pointer is 1 beforehand so post-reset order exposes its reset.
        issue(2'b01, 3, 16'h0200);
        wait_done();
        issue(2'b01, 3, 16'h0300);
        cyc = 0;
        while (!(m_rvalid && m_rready) && cyc < 500) begin
            @(negedge ACLK);
            cyc++;
        end
        check("first_beat_timeout", 64'(cyc >= 500), 64'(0));
        @(posedge ACLK);
        #3;
        ARESETn = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_valids", 64'({s_arready, s_rvalid, m_arvalid, m_rready}), 64'(0));
        check("midrst_err", 64'(rlast_err), 64'(0));
        exp_ar.delete();
        exp_r.delete();
        for (int i = 0; i < N; i++) req_pend[i] = 1'b0;
        ptr_m = 0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        issue(2'b11, 2, 16'h0500);
        wait_done();
        issue(2'b11, -1, '0);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
